imem_arbiter: RTL
=================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1025, meaning number of 64-bit words in the attached instruction memory.
REQ-002 SHALL have parameter AW, default 64, meaning address width.
REQ-003 SHALL have parameter DW, default 64, meaning data width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ld_valid  input  1  loader write request.
REQ-007 ld_ready  output  1  loader request accepted this cycle.
REQ-008 ld_addr  input  AW  loader word address.
REQ-009 ld_data  input  DW  loader write data.
REQ-010 ld_last  input  1  marks the final load word of a boot image.
REQ-011 ld_err  output  1  one-cycle pulse: the accepted load address was out of range.
REQ-012 fe_valid  input  1  fetch read request.
REQ-013 fe_ready  output  1  fetch request accepted this cycle.
REQ-014 fe_addr  input  AW  fetch word address.
REQ-015 fe_rvalid  output  1  fetch response valid.
REQ-016 fe_rdata  output  DW  fetch response data.
REQ-017 fe_err  output  1  fetch response is an out-of-range error; qualified by fe_rvalid.
REQ-018 boot_done  output  1  high once the boot image load has completed.
REQ-019 mem_enable, mem_read  output  1 each  drive the memory enable and read (1) / write (0) select.
REQ-020 mem_address  output  AW  drives the memory address.
REQ-021 mem_data_in  output  DW  drives the memory write data.
REQ-022 mem_data_out  input  DW  memory read data, valid the cycle after a read edge.

Function
REQ-023 SHALL implement an FSM with states BOOT, RUN.
- BOOT: only loads are granted; fe_ready=0.
- RUN: loads and fetches are arbitrated.
REQ-024 In BOOT, ld_ready SHALL equal ld_valid.
REQ-025 An accepted load with ld_last=1 SHALL move the FSM BOOT->RUN at that edge, and boot_done SHALL rise in the next cycle.
REQ-026 In RUN, a single requester valid SHALL be granted in the same cycle.
REQ-027 In RUN, with both requesters valid, grant SHALL alternate round-robin; last_grant is a register, reset to fetch, so the first contention grants load.
REQ-028 At most one of ld_ready and fe_ready SHALL be high in any cycle.
REQ-029 Memory outputs SHALL be driven combinationally from the grant in the grant cycle; the memory samples them at the next posedge.
- Load grant: mem_enable=1, mem_read=0, mem_address=ld_addr, mem_data_in=ld_data.
- Fetch grant: mem_enable=1, mem_read=1, mem_address=fe_addr.
- No grant: mem_enable=0, mem_read=1, mem_address and mem_data_in hold 0.
REQ-030 Out-of-range address (addr >= DEPTH, full AW-bit compare):
- The request SHALL still be accepted, with mem_enable=0.
- A load SHALL pulse ld_err in the next cycle.
- A fetch SHALL give fe_rvalid=1, fe_err=1, fe_rdata=0 in the next cycle.
REQ-031 Fetch latency SHALL be 1 cycle.
- fe_rvalid registered high in the cycle after acceptance; fe_rdata=mem_data_out in that cycle.
- Back-to-back fetches SHALL give back-to-back responses; there is no response backpressure.
REQ-032 An ld_last in RUN SHALL be ignored for state; the load itself proceeds normally.
REQ-033 Requests SHALL NOT be queued; a requester holds valid and its payload until its ready is seen.

Reset
REQ-034 Reset asserted SHALL force, asynchronously:
- state=BOOT, boot_done=0, last_grant=fetch;
- fe_rvalid=0, fe_err=0, ld_err=0.
REQ-035 During reset, ld_ready, fe_ready and mem_enable SHALL be 0.
REQ-036 Reset mid-operation SHALL discard any pending fetch response; no fe_rvalid appears after deassertion without a new request.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the grant-owner enum (LOAD, FETCH) and the DEPTH/AW/DW defaults.
REQ-038 One sub-module, imem_rr_arb (2-way round-robin grant with last_grant register), is natural; everything else stays in imem_arbiter.

Verification
REQ-039 Boot, 3 loads, ld_last on the 3rd, fe_valid held high throughout -> fe_ready=0 until the cycle after the 3rd accept; boot_done=1 from that cycle.
REQ-040 RUN, fetch addr 2 after load addr 2 data 0xDEAD_BEEF_0000_0001 -> fe_rvalid one cycle after fe_ready, with fe_rdata=0xDEAD_BEEF_0000_0001 and fe_err=0.
REQ-041 RUN, ld_valid and fe_valid both held for 4 cycles -> grants L,F,L,F; never both ready in one cycle.
REQ-042 Fetch addr 1025 and load addr 0xFFFF_FFFF_FFFF_FFFF -> mem_enable=0 for both; fe_err=1 with fe_rdata=0; ld_err pulses for exactly 1 cycle.
REQ-043 rst_n low for 1 cycle in RUN, in the cycle after a fetch accept -> fe_rvalid stays 0, state=BOOT, boot_done=0.
REQ-044 8 consecutive fetches, addrs 0..7 -> 8 consecutive fe_rvalid cycles, each with the matching data.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// imem_arbiter_pkg: shared types and default sizes for the imem arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package imem_arbiter_pkg;

  localparam int unsigned DEPTH_DEFAULT = 1025;
  localparam int unsigned AW_DEFAULT    = 64;
  localparam int unsigned DW_DEFAULT    = 64;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    FETCH = 1'b1
  } owner_e;

endpackage

`default_nettype wire

// File: rtl/imem_rr_arb.sv
// ----------------------------------------------------------------------------
// imem_rr_arb: 2-way round-robin grant between loader and fetch. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_rr_arb
  import imem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic ld_req_i,
  input  logic fe_req_i,
  output logic ld_gnt_o,
  output logic fe_gnt_o
);

  owner_e last_grant_q, last_grant_d;

  always_comb begin
    ld_gnt_o     = 1'b0;
    fe_gnt_o     = 1'b0;
    last_grant_d = last_grant_q;
    if (rst_n) begin
      if (!run_i) begin
        ld_gnt_o = ld_req_i;
      end else if (ld_req_i && fe_req_i) begin
        // Contention goes to whoever did not win last time.
        ld_gnt_o = (last_grant_q == FETCH);
        fe_gnt_o = (last_grant_q == LOAD);
      end else begin
        ld_gnt_o = ld_req_i;
        fe_gnt_o = fe_req_i;
      end
    end
    if (run_i && ld_gnt_o) begin
      last_grant_d = LOAD;
    end else if (run_i && fe_gnt_o) begin
      last_grant_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= FETCH;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter: boot-loader / instruction-fetch arbiter for a 1-cycle memory. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_err,
  input  logic          fe_valid,
  output logic          fe_ready,
  input  logic [AW-1:0] fe_addr,
  output logic          fe_rvalid,
  output logic [DW-1:0] fe_rdata,
  output logic          fe_err,
  output logic          boot_done,
  output logic          mem_enable,
  output logic          mem_read,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_e state_q, state_d;
  logic   boot_done_q, boot_done_d;
  logic   fe_rvalid_q, fe_rvalid_d;
  logic   fe_err_q, fe_err_d;
  logic   ld_err_q, ld_err_d;
  logic   ld_gnt, fe_gnt;
  logic   ld_oor, fe_oor;

  assign ld_oor = (ld_addr >= DEPTH_A);
  assign fe_oor = (fe_addr >= DEPTH_A);

  imem_rr_arb u_rr_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (state_q == RUN),
    .ld_req_i (ld_valid),
    .fe_req_i (fe_valid),
    .ld_gnt_o (ld_gnt),
    .fe_gnt_o (fe_gnt)
  );

  assign ld_ready = ld_gnt;
  assign fe_ready = fe_gnt;

  // Out-of-range requests are accepted but never reach the memory.
  always_comb begin
    mem_enable  = 1'b0;
    mem_read    = 1'b1;
    mem_address = '0;
    mem_data_in = '0;
    if (ld_gnt) begin
      mem_enable  = !ld_oor;
      mem_read    = 1'b0;
      mem_address = ld_addr;
      mem_data_in = ld_data;
    end else if (fe_gnt) begin
      mem_enable  = !fe_oor;
      mem_address = fe_addr;
    end
  end

  always_comb begin
    state_d     = state_q;
    boot_done_d = boot_done_q;
    fe_rvalid_d = fe_gnt;
    fe_err_d    = fe_gnt && fe_oor;
    ld_err_d    = ld_gnt && ld_oor;
    unique case (state_q)
      BOOT: begin
        if (ld_gnt && ld_last) begin
          state_d     = RUN;
          boot_done_d = 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      boot_done_q <= 1'b0;
      fe_rvalid_q <= 1'b0;
      fe_err_q    <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_done_q <= boot_done_d;
      fe_rvalid_q <= fe_rvalid_d;
      fe_err_q    <= fe_err_d;
      ld_err_q    <= ld_err_d;
    end
  end

  assign boot_done = boot_done_q;
  assign fe_rvalid = fe_rvalid_q;
  assign fe_err    = fe_err_q;
  assign ld_err    = ld_err_q;
  assign fe_rdata  = (fe_rvalid_q && !fe_err_q) ? mem_data_out : '0;

endmodule

`default_nettype wire
